fifo_write_arbiter: RTL and testbench

//  Round-robin, packet-atomic arbiter sharing the single write port of a synchronous

---
 rtl/fifo_write_arbiter_pkg.sv | 20 ++
 rtl/fifo_write_arbiter_if.sv | 30 +++
 rtl/fifo_write_arbiter_rr_priority_picker.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 98 +++++++++
 tb/tb_fifo_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and FIFO word layout.
// The FIFO read side imports this package so both ends decode {last, src_id, data} identically.
package fifo_write_arbiter_pkg;

    typedef logic [0:0] state_t;

    localparam state_t STATE_IDLE  = 1'b0;
    localparam state_t STATE_GRANT = 1'b1;

    localparam int unsigned DATA_LSB = 0;

    function automatic int unsigned id_lsb(int unsigned data_width);
        return data_width;
    endfunction

    function automatic int unsigned last_bit(int unsigned data_width, int unsigned id_width);
        return data_width + id_width;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Request-side and FIFO-side signals of the write arbiter.
// master = sources plus FIFO status, slave = the arbiter.
interface fifo_write_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_WIDTH   = 2,
    parameter int unsigned DATA_WIDTH = 30,
    parameter int unsigned ADDR_WIDTH = 7
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_is_full;
    logic [ADDR_WIDTH-1:0]         fifo_words_used;
    logic                          fifo_write_en;
    logic [DATA_WIDTH+ID_WIDTH:0]  fifo_write_data;
    logic                          busy;

    modport master (
        output req_valid, req_last, req_data, fifo_is_full, fifo_words_used,
        input  req_ready, fifo_write_en, fifo_write_data, busy
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_is_full, fifo_words_used,
        output req_ready, fifo_write_en, fifo_write_data, busy
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set bit of valid scanning rr_ptr, rr_ptr+1, ...
// modulo NUM_REQ.
module fifo_write_arbiter_rr_priority_picker #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] winner
);

    logic [NUM_REQ-1:0] rotated;
    int                 idx;

    // Bit k of rotated is source (rr_ptr + k) mod NUM_REQ.
    assign rotated = NUM_REQ'({valid, valid} >> rr_ptr);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        // Descending scan so the lowest offset from rr_ptr is written last and wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                found = 1'b1;
                idx   = k + int'(rr_ptr);
                if (idx >= int'(NUM_REQ)) begin
                    idx = idx - int'(NUM_REQ);
                end
                winner = ID_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Packet-atomic round-robin arbiter for the single write port of a show-ahead FIFO.
// The FIFO does no overflow checking; this block never writes while fifo_is_full is high.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_WIDTH     = 2,
    parameter int unsigned DATA_WIDTH   = 30,
    parameter int unsigned ADDR_WIDTH   = 7,
    parameter int unsigned START_THRESH = 120
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_write_arbiter_if.slave  bus
);

    localparam int unsigned WORD_WIDTH = DATA_WIDTH + ID_WIDTH + 1;
    localparam int unsigned LAST_BIT   = last_bit(DATA_WIDTH, ID_WIDTH);
    localparam int unsigned ID_LSB     = id_lsb(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic                  found;
    logic [ID_WIDTH-1:0]   winner;
    logic                  start_ok;
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    ready;
    logic                  write_en;
    logic [WORD_WIDTH-1:0] write_data;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_data
        assign data_arr[i] = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    fifo_write_arbiter_rr_priority_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .valid  (bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .found  (found),
        .winner (winner)
    );

    // Threshold only gates new grants; an in-flight packet is limited by fifo_is_full alone.
    assign start_ok = 32'(bus.fifo_words_used) < START_THRESH;
    assign next_ptr = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + ID_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        ready      = '0;
        write_en   = 1'b0;
        write_data = '0;
        case (state_q)
            STATE_IDLE: begin
                if (found && start_ok) begin
                    state_d = STATE_GRANT;
                    grant_d = winner;
                end
            end
            STATE_GRANT: begin
                ready[grant_q] = ~bus.fifo_is_full;
                write_en       = bus.req_valid[grant_q] & ~bus.fifo_is_full;
                if (write_en) begin
                    write_data[LAST_BIT]                = bus.req_last[grant_q];
                    write_data[ID_LSB +: ID_WIDTH]      = grant_q;
                    write_data[DATA_LSB +: DATA_WIDTH]  = data_arr[grant_q];
                    if (bus.req_last[grant_q]) begin
                        state_d  = STATE_IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= STATE_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.req_ready       = ready;
    assign bus.fifo_write_en   = write_en;
    assign bus.fifo_write_data = write_data;
    assign bus.busy            = (state_q == STATE_GRANT);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus random traffic, every cycle checked
// against a packet-level reference model of owner / round-robin pointer.
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       full;
    logic [6:0] used;

    always #5 clk = ~clk;

    fifo_write_arbiter_if #(
        .NUM_REQ    (4),
        .ID_WIDTH   (2),
        .DATA_WIDTH (30),
        .ADDR_WIDTH (7)
    ) bus ();

    fifo_write_arbiter #(
        .NUM_REQ      (4),
        .ID_WIDTH     (2),
        .DATA_WIDTH   (30),
        .ADDR_WIDTH   (7),
        .START_THRESH (120)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: owning source (-1 = none) and next round-robin start.
    int owner;
    int ptr;
    // Per-source stream state: beats left in current packet, queued packets, length, data seq.
    int rem  [NR];
    int npk  [NR];
    int plen [NR];
    int seq  [NR];
    bit gate [NR];

    logic [NR-1:0] cur_valid;
    logic [NR-1:0] cur_last;
    logic [DW-1:0] cur_data [NR];

    logic [32:0] log_w [$];
    int          log_c [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(input int s, input int q);
        return DW'((s << 24) | q);
    endfunction

    function automatic bit model_idle();
        int r;
        r = 0;
        for (int i = 0; i < NR; i++) r += rem[i];
        return (owner < 0) && (r == 0);
    endfunction

    task automatic model_reset();
        owner = -1;
        ptr   = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i]  = 0;
            npk[i]  = 0;
            gate[i] = 1'b1;
        end
    endtask

    task automatic add_pkt(input int s, input int n, input int len);
        plen[s] = len;
        npk[s] += n;
        if (rem[s] == 0 && npk[s] > 0) begin
            rem[s] = len;
            npk[s]--;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            cur_valid[i] = (rem[i] > 0) && gate[i];
            cur_last[i]  = (rem[i] == 1);
            cur_data[i]  = beat_data(i, seq[i]);
            bus.req_data[i*DW +: DW] = cur_data[i];
        end
        bus.req_valid       = cur_valid;
        bus.req_last        = cur_last;
        bus.fifo_is_full    = full;
        bus.fifo_words_used = used;
    endtask

    task automatic step();
        logic [NR-1:0] er;
        logic          ew;
        logic [32:0]   ed;
        logic          eb;
        int            s;
        drive();
        @(negedge clk);
        er = '0;
        ew = 1'b0;
        ed = '0;
        eb = (owner >= 0);
        if (owner >= 0) begin
            if (!full) er[owner] = 1'b1;
            ew = cur_valid[owner] && !full;
            if (ew) ed = {cur_last[owner], 2'(owner), cur_data[owner]};
        end
        check("req_ready", 64'(bus.req_ready), 64'(er));
        check("write_en", 64'(bus.fifo_write_en), 64'(ew));
        check("write_data", 64'(bus.fifo_write_data), 64'(ed));
        check("busy", 64'(bus.busy), 64'(eb));
        if (bus.fifo_write_en === 1'b1) begin
            log_w.push_back(bus.fifo_write_data);
            log_c.push_back(cyc);
        end
        if (owner < 0) begin
            if (cur_valid != '0 && used < 7'd120) begin
                for (int k = 0; k < NR; k++) begin
                    s = (ptr + k) % NR;
                    if (owner < 0 && cur_valid[s]) owner = s;
                end
            end
        end else if (ew) begin
            s = owner;
            rem[s]--;
            seq[s]++;
            if (rem[s] == 0 && npk[s] > 0) begin
                rem[s] = plen[s];
                npk[s]--;
            end
            if (cur_last[s]) begin
                ptr   = (s + 1) % NR;
                owner = -1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_log();
        log_w.delete();
        log_c.delete();
    endtask

    initial begin
        int c0;
        int s0;
        for (int i = 0; i < NR; i++) seq[i] = 0;
        model_reset();
        full  = 1'b0;
        used  = '0;
        reset = 1'b0;
        bus.req_valid       = '1;
        bus.req_last        = '0;
        bus.req_data        = '0;
        bus.fifo_is_full    = 1'b0;
        bus.fifo_words_used = '0;
        #3;
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_write_en", 64'(bus.fifo_write_en), 64'd0);
        check("rst_write_data", 64'(bus.fifo_write_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        reset = 1'b1;

        // Round robin over continuous 2-beat packets.
        clear_log();
        for (int s = 0; s < NR; s++) add_pkt(s, (s == 0) ? 2 : 1, 2);
        repeat (15) step();
        check("rr_count", 64'(log_w.size()), 64'd10);
        for (int j = 0; j < 10 && j < log_w.size(); j++) begin
            check("rr_id", 64'(log_w[j][31:30]), 64'((j / 2) % 4));
            check("rr_last", 64'(log_w[j][32]), 64'(j % 2));
        end
        if (log_c.size() >= 3) check("rr_gap", 64'(log_c[2] - log_c[0]), 64'd3);

        // Atomicity: src2 requests while src1 is mid-packet.
        clear_log();
        add_pkt(1, 1, 5);
        repeat (2) step();
        add_pkt(2, 1, 3);
        repeat (8) step();
        check("atom_count", 64'(log_w.size()), 64'd8);
        for (int j = 0; j < 5 && j < log_w.size(); j++)
            check("atom_id1", 64'(log_w[j][31:30]), 64'd1);
        if (log_w.size() > 5) check("atom_id2", 64'(log_w[5][31:30]), 64'd2);

        // FIFO full stall mid-packet.
        clear_log();
        s0 = seq[3];
        add_pkt(3, 1, 6);
        repeat (3) step();
        full = 1'b1;
        repeat (4) step();
        full = 1'b0;
        repeat (5) step();
        check("full_count", 64'(log_w.size()), 64'd6);
        for (int j = 0; j < 6 && j < log_w.size(); j++)
            check("full_data", 64'(log_w[j][29:0]), 64'(beat_data(3, s0 + j)));

        // Start threshold blocks new grants.
        clear_log();
        used = 7'd120;
        add_pkt(0, 1, 1);
        repeat (3) step();
        check("thr_no_write", 64'(log_w.size()), 64'd0);
        check("thr_busy", 64'(bus.busy), 64'd0);
        used = 7'd119;
        c0 = cyc;
        repeat (2) step();
        check("thr_count", 64'(log_w.size()), 64'd1);
        if (log_c.size() > 0) check("thr_write_cycle", 64'(log_c[0]), 64'(c0 + 1));
        step();
        used = '0;

        // Random traffic with stalls, valid gaps and threshold crossings.
        for (int n = 0; n < 400; n++) begin
            full = ($urandom % 6) == 0;
            used = 7'(112 + ($urandom % 12));
            for (int i = 0; i < NR; i++) begin
                gate[i] = ($urandom % 5) != 0;
                if (rem[i] == 0 && npk[i] == 0 && ($urandom % 8) == 0)
                    add_pkt(i, 1, 1 + int'($urandom % 5));
            end
            step();
        end
        full = 1'b0;
        used = '0;
        for (int i = 0; i < NR; i++) gate[i] = 1'b1;
        for (int g = 0; g < 100 && !model_idle(); g++) step();
        step();
        check("drain_busy", 64'(bus.busy), 64'd0);

        // Asynchronous reset while beat 3 of 6 is presented.
        clear_log();
        add_pkt(2, 1, 6);
        repeat (3) step();
        drive();
        reset = 1'b0;
        #1;
        check("arst_ready", 64'(bus.req_ready), 64'd0);
        check("arst_write_en", 64'(bus.fifo_write_en), 64'd0);
        check("arst_write_data", 64'(bus.fifo_write_data), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        model_reset();
        add_pkt(3, 1, 1);
        add_pkt(1, 1, 1);
        #2;
        reset = 1'b1;
        repeat (6) step();
        check("arst_count", 64'(log_w.size()), 64'd4);
        if (log_w.size() >= 4) begin
            check("arst_first_id", 64'(log_w[2][31:30]), 64'd1);
            check("arst_second_id", 64'(log_w[3][31:30]), 64'd3);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
